// File: rtl/fmmu_sched.sv
// Walks one logical sub-datagram across all FMMU channels, one bus transfer per overlapping channel.
// Optional per-channel enable input when FMMU_CH_ENABLE_EN is defined.
module fmmu_sched #(
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic [31:0]       sub_address,
  input  logic [7:0]        sub_len,
  input  logic              subdv,
  input  logic [32*NCH-1:0] cfg_log_start,
  input  logic [8*NCH-1:0]  cfg_log_len,
  input  logic [16*NCH-1:0] cfg_phy_start,
`ifdef FMMU_CH_ENABLE_EN
  input  logic [NCH-1:0]    cfg_ch_en,
`endif
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic [15:0]       bus_address,
  output logic [7:0]        bus_len,
  output logic [7:0]        bus_offset,
  output logic [2:0]        bus_ch,
  output logic              done,
  output logic              hit
);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

  state_t st, st_nxt;

  // Configuration is padded to 8 channels so the channel index can be a plain 3-bit select.
  logic [255:0] ls_pad, ls_q;
  logic [63:0]  ll_pad, ll_q;
  logic [127:0] ps_pad, ps_q;
  logic [31:0]  sub_addr_q;
  logic [7:0]   sub_len_q;
  logic [2:0]   ch_idx;
  logic         hit_q;
  logic         ch_on;

  always_comb begin
    ls_pad = '0;
    ll_pad = '0;
    ps_pad = '0;
    ls_pad[32*NCH-1:0] = cfg_log_start;
    ll_pad[8*NCH-1:0]  = cfg_log_len;
    ps_pad[16*NCH-1:0] = cfg_phy_start;
  end

`ifdef FMMU_CH_ENABLE_EN
  logic [7:0] en_pad, en_q;
  always_comb begin
    en_pad = '0;
    en_pad[NCH-1:0] = cfg_ch_en;
  end
  assign ch_on = en_q[ch_idx];
`else
  assign ch_on = 1'b1;
`endif

  logic [31:0] cur_ls;
  logic [7:0]  cur_ll;
  logic [15:0] cur_ps;
  logic [32:0] sa, se, la, le, s_max, e_min;
  logic        map, last;

  assign cur_ls = ls_q[{ch_idx, 5'd0} +: 32];
  assign cur_ll = ll_q[{ch_idx, 3'd0} +: 8];
  assign cur_ps = ps_q[{ch_idx, 4'd0} +: 16];

  // 33-bit math so windows ending exactly at 2^32 still compare correctly.
  assign sa    = {1'b0, sub_addr_q};
  assign se    = sa + {25'd0, sub_len_q};
  assign la    = {1'b0, cur_ls};
  assign le    = la + {25'd0, cur_ll};
  assign s_max = (sa > la) ? sa : la;
  assign e_min = (se < le) ? se : le;
  assign map   = (e_min > s_max) && ch_on;
  assign last  = (ch_idx == 3'(NCH-1));

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) st <= IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:  if (subdv) st_nxt = CALC;
      CALC:  if (map) st_nxt = ISSUE;
             else if (last) st_nxt = DONE;
      ISSUE: if (bus_ack) st_nxt = last ? DONE : CALC;
      DONE:  st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      ls_q        <= '0;
      ll_q        <= '0;
      ps_q        <= '0;
      sub_addr_q  <= '0;
      sub_len_q   <= '0;
      ch_idx      <= '0;
      hit_q       <= 1'b0;
      bus_address <= '0;
      bus_len     <= '0;
      bus_offset  <= '0;
      bus_ch      <= '0;
`ifdef FMMU_CH_ENABLE_EN
      en_q        <= '0;
`endif
    end else begin
      case (st)
        IDLE: if (subdv) begin
          ls_q       <= ls_pad;
          ll_q       <= ll_pad;
          ps_q       <= ps_pad;
          sub_addr_q <= sub_address;
          sub_len_q  <= sub_len;
          ch_idx     <= '0;
          hit_q      <= 1'b0;
`ifdef FMMU_CH_ENABLE_EN
          en_q       <= en_pad;
`endif
        end
        CALC: if (map) begin
          bus_address <= cur_ps + 16'(s_max - la);
          bus_len     <= 8'(e_min - s_max);
          bus_offset  <= 8'(s_max - sa);
          bus_ch      <= ch_idx;
          hit_q       <= 1'b1;
        end else if (!last) begin
          ch_idx <= ch_idx + 3'd1;
        end
        ISSUE: if (bus_ack && !last) ch_idx <= ch_idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign busy    = (st != IDLE);
  assign bus_req = (st == ISSUE);
  assign done    = (st == DONE);
  assign hit     = (st == DONE) && hit_q;

endmodule

// File: tb/tb_fmmu_sched.sv
// Directed bench for fmmu_sched (NCH=4) with hand-computed transfers and done timing.
module tb_fmmu_sched;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              RSTN = 1'b0;
  logic [31:0]       sub_address = '0;
  logic [7:0]        sub_len = '0;
  logic              subdv = 1'b0;
  logic [32*NCH-1:0] cfg_log_start = '0;
  logic [8*NCH-1:0]  cfg_log_len = '0;
  logic [16*NCH-1:0] cfg_phy_start = '0;
`ifdef FMMU_CH_ENABLE_EN
  logic [NCH-1:0]    cfg_ch_en = '1;
`endif
  logic              busy, bus_req, done, hit;
  logic              bus_ack = 1'b1;
  logic [15:0]       bus_address;
  logic [7:0]        bus_len, bus_offset;
  logic [2:0]        bus_ch;

  fmmu_sched #(.NCH(NCH)) dut (
    .clk(clk), .RSTN(RSTN), .sub_address(sub_address), .sub_len(sub_len), .subdv(subdv),
    .cfg_log_start(cfg_log_start), .cfg_log_len(cfg_log_len), .cfg_phy_start(cfg_phy_start),
`ifdef FMMU_CH_ENABLE_EN
    .cfg_ch_en(cfg_ch_en),
`endif
    .busy(busy), .bus_req(bus_req), .bus_ack(bus_ack), .bus_address(bus_address),
    .bus_len(bus_len), .bus_offset(bus_offset), .bus_ch(bus_ch), .done(done), .hit(hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] tr_addr [4];
  logic [7:0]  tr_len  [4];
  logic [7:0]  tr_off  [4];
  logic [2:0]  tr_ch   [4];
  int          n_tr;
  int          done_cyc;
  logic        hit_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [31:0] ls, input logic [7:0] ll, input logic [15:0] ps);
    cfg_log_start[32*i +: 32] = ls;
    cfg_log_len[8*i +: 8]     = ll;
    cfg_phy_start[16*i +: 16] = ps;
  endtask

  task automatic start(input logic [31:0] a, input logic [7:0] l);
    @(negedge clk);
    sub_address = a;
    sub_len     = l;
    subdv       = 1'b1;
    @(posedge clk);
    #1 subdv = 1'b0;
  endtask

  // Records transfers (bus_ack assumed high) and the cycle of done, counted from the accepting edge.
  task automatic sweep(input logic [31:0] a, input logic [7:0] l, input logic poke);
    n_tr = 0; done_cyc = -1; hit_v = 1'b0;
    start(a, l);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 2) subdv = 1'b1;
      if (poke && cyc == 3) subdv = 1'b0;
      if (bus_req && n_tr < 4) begin
        tr_addr[n_tr] = bus_address; tr_len[n_tr] = bus_len;
        tr_off[n_tr] = bus_offset;   tr_ch[n_tr] = bus_ch;
        n_tr++;
      end
      if (done) begin
        done_cyc = cyc; hit_v = hit;
        break;
      end
    end
    subdv = 1'b0;
  endtask

  initial begin
    int cyc;
    logic stable;
    int ndone;

    #3;
    chk("rst_busy", busy, 0);    chk("rst_req", bus_req, 0);
    chk("rst_done", done, 0);    chk("rst_hit", hit, 0);
    chk("rst_addr", bus_address, 0); chk("rst_len", bus_len, 0);
    chk("rst_off", bus_offset, 0);   chk("rst_ch", bus_ch, 0);
    @(negedge clk); RSTN = 1'b1;

    set_ch(0, 32'h1000, 8'd16, 16'h0800);

    sweep(32'h1004, 8'd4, 1'b0);
    chk("t1_ntr", n_tr, 1);
    chk("t1_addr", tr_addr[0], 16'h0804); chk("t1_len", tr_len[0], 4);
    chk("t1_off", tr_off[0], 0);          chk("t1_ch", tr_ch[0], 0);
    chk("t1_hit", hit_v, 1);              chk("t1_done", done_cyc, 6);

    sweep(32'h0FFC, 8'd8, 1'b0);
    chk("t2_ntr", n_tr, 1);
    chk("t2_addr", tr_addr[0], 16'h0800); chk("t2_len", tr_len[0], 4);
    chk("t2_off", tr_off[0], 4);

    sweep(32'h100C, 8'd8, 1'b0);
    chk("t3_addr", tr_addr[0], 16'h080C); chk("t3_len", tr_len[0], 4);
    chk("t3_off", tr_off[0], 0);

    sweep(32'h0FF0, 8'd64, 1'b0);
    chk("t4_ntr", n_tr, 1);
    chk("t4_addr", tr_addr[0], 16'h0800); chk("t4_len", tr_len[0], 16);
    chk("t4_off", tr_off[0], 16);

    set_ch(2, 32'h1020, 8'd8, 16'h0900);
    sweep(32'h0FF0, 8'd64, 1'b0);
    chk("t5_ntr", n_tr, 2);
    chk("t5_ch0", tr_ch[0], 0);           chk("t5_ch1", tr_ch[1], 2);
    chk("t5_addr1", tr_addr[1], 16'h0900); chk("t5_len1", tr_len[1], 8);
    chk("t5_off1", tr_off[1], 48);        chk("t5_done", done_cyc, 7);
    chk("t5_hit", hit_v, 1);
    set_ch(2, 32'h0, 8'd0, 16'h0);

    sweep(32'h2000, 8'd8, 1'b1);
    chk("t6_ntr", n_tr, 0); chk("t6_done", done_cyc, 5); chk("t6_hit", hit_v, 0);
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    @(negedge clk);
    chk("t6_no_restart", busy, 0);

    sweep(32'h1004, 8'd0, 1'b0);
    chk("t7_ntr", n_tr, 0); chk("t7_done", done_cyc, 5); chk("t7_hit", hit_v, 0);

    // Arbiter stall: bus_req first seen at cycle 2, held 10 more cycles, then acked.
    bus_ack = 1'b0;
    start(32'h1004, 8'd4);
    cyc = 0;
    while (!bus_req && cyc < 20) begin @(negedge clk); cyc++; end
    chk("t8_req_cyc", cyc, 2);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); cyc++;
      if (!bus_req || bus_address != 16'h0804 || bus_len != 8'd4 ||
          bus_offset != 8'd0 || bus_ch != 3'd0) stable = 1'b0;
    end
    chk("t8_stable", stable, 1);
    bus_ack = 1'b1;
    while (!done && cyc < 60) begin @(negedge clk); cyc++; end
    chk("t8_done", cyc, 16); chk("t8_hit", hit, 1);

    // Reset mid-ISSUE.
    bus_ack = 1'b0;
    start(32'h1004, 8'd4);
    cyc = 0;
    while (!bus_req && cyc < 20) begin @(negedge clk); cyc++; end
    chk("t9_req", bus_req, 1);
    #2 RSTN = 1'b0;
    #1;
    chk("t9_req0", bus_req, 0);  chk("t9_busy0", busy, 0);
    chk("t9_addr0", bus_address, 0); chk("t9_len0", bus_len, 0);
    chk("t9_off0", bus_offset, 0);   chk("t9_done0", done, 0);
    @(negedge clk); RSTN = 1'b1;
    bus_ack = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (done) ndone++; end
    chk("t9_no_done", ndone, 0);

`ifdef FMMU_CH_ENABLE_EN
    cfg_ch_en = 4'b1110;
    sweep(32'h1004, 8'd4, 1'b0);
    chk("t10_ntr", n_tr, 0); chk("t10_done", done_cyc, 5); chk("t10_hit", hit_v, 0);
    cfg_ch_en = 4'b1111;
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
